// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the pipelined FFT.
// Provides the default frame size, N, and the bitrev() address helper.
package fft_pkg;

  localparam int LGSIZE_DEF = 11;
  localparam int N          = 1 << LGSIZE_DEF;
  localparam int ADDR_MAX   = 16;

  // Reverse the low lg bits of addr; upper bits come back zero.
  function automatic logic [ADDR_MAX-1:0] bitrev(
    input logic [ADDR_MAX-1:0] addr,
    input int                  lg
  );
    logic [ADDR_MAX-1:0] r;
    logic [3:0]          j;
    r = '0;
    j = '0;
    for (int i = 0; i < ADDR_MAX; i++) begin
      if (i < lg) begin
        j = 4'(lg - 1 - i);
        r[i[3:0]] = addr[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_mem.sv
// fft_pingpong_mem: 2*N x WIDTH simple dual-port RAM, registered read.
// Ports: write {bank,addr}/data/enable, read {bank,addr}/enable/data.
module fft_pingpong_mem #(
  parameter int LGSIZE = 11,
  parameter int WIDTH  = 42
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGSIZE:0]   i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [LGSIZE:0]   i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  localparam int DEPTH = 2 << LGSIZE;

  logic [WIDTH-1:0] mem [DEPTH];

  // Data is never reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong reorder of a bit-reversed FFT stream, with
// frame tracking. In: i_clk/i_reset/i_ce/i_sync/i_sample.
// Out: o_result, o_valid, o_sync, o_resync (mid-frame sync dropped a frame).
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int LGSIZE     = LGSIZE_DEF,
  parameter int WIDTH      = 42,
  parameter bit OPT_BITREV = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  output logic             o_sync,
  output logic             o_resync
);

  typedef logic [LGSIZE-1:0] addr_t;

  localparam addr_t LAST = addr_t'((1 << LGSIZE) - 1);

  logic             wr_active;
  logic             wr_bank;
  addr_t            wr_addr;
  logic             rd_bank;
  addr_t            rd_addr;
  logic [1:0]       full;
  logic [1:0]       full_d;
  logic             rd_vld_q;
  logic             rd_sync_q;

  logic             we;
  logic             resync;
  logic             wr_last;
  logic             rd_go;
  logic             rd_last;
  addr_t            wr_slot;
  addr_t            rd_slot;
  logic [LGSIZE:0]  mem_wr_addr;
  logic [LGSIZE:0]  mem_rd_addr;
  logic [WIDTH-1:0] mem_q;

  assign we      = i_ce && (wr_active || i_sync);
  assign resync  = i_ce && i_sync && wr_active && (wr_addr != '0);
  assign wr_slot = i_sync ? '0 : wr_addr;
  assign wr_last = we && (wr_slot == LAST);

  // A resync aborts the read side on the same ce.
  assign rd_go   = i_ce && full[rd_bank] && !resync;
  assign rd_last = rd_go && (rd_addr == LAST);

  if (OPT_BITREV) begin : g_rev
    assign rd_slot = addr_t'(bitrev(16'(rd_addr), LGSIZE));
  end else begin : g_nat
    assign rd_slot = rd_addr;
  end

  assign mem_wr_addr = {wr_bank, wr_slot};
  assign mem_rd_addr = {rd_bank, rd_slot};

  fft_pingpong_mem #(
    .LGSIZE (LGSIZE),
    .WIDTH  (WIDTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (we),
    .i_wr_addr (mem_wr_addr),
    .i_wr_data (i_sample),
    .i_rd_en   (i_ce),
    .i_rd_addr (mem_rd_addr),
    .o_rd_data (mem_q)
  );

  // Set after clear: a bank finishing its write wins the same ce.
  always_comb begin
    full_d = full;
    if (rd_last) full_d[rd_bank] = 1'b0;
    if (wr_last) full_d[wr_bank] = 1'b1;
    if (resync)  full_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      full <= '0;
    end else if (i_ce) begin
      full <= full_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_active <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
    end else if (we) begin
      wr_active <= 1'b1;
      if (wr_last) begin
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_addr <= wr_slot + addr_t'(1);
      end
    end
  end

  // After a resync the read side follows the bank now being refilled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      rd_vld_q  <= 1'b0;
      rd_sync_q <= 1'b0;
    end else if (resync) begin
      rd_bank   <= wr_bank;
      rd_addr   <= '0;
      rd_vld_q  <= 1'b0;
      rd_sync_q <= 1'b0;
    end else if (i_ce) begin
      rd_vld_q  <= rd_go;
      rd_sync_q <= rd_go && (rd_addr == '0);
      if (rd_go) begin
        if (rd_last) begin
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_addr <= rd_addr + addr_t'(1);
        end
      end
    end
  end

  // o_resync is sampled every clock so it is always one clock wide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_result <= '0;
      o_valid  <= 1'b0;
      o_sync   <= 1'b0;
      o_resync <= 1'b0;
    end else begin
      o_resync <= resync;
      if (resync) begin
        o_valid <= 1'b0;
        o_sync  <= 1'b0;
      end else if (i_ce) begin
        o_valid <= rd_vld_q;
        o_sync  <= rd_sync_q;
        if (rd_vld_q) begin
          o_result <= mem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: random + directed bench for fft_reorder_buf.
// Two instances (bit-reversed and natural) share stimulus.
module tb_fft_reorder_buf;

  localparam int LG  = 3;
  localparam int N   = 1 << LG;
  localparam int W   = 8;
  localparam int ARR = 16384;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] sample = '0;

  logic [W-1:0] r1, r2;
  logic         v1, v2, s1, s2, rs1, rs2;

  int errors = 0;
  int checks = 0;

  fft_reorder_buf #(
    .LGSIZE (LG), .WIDTH (W), .OPT_BITREV (1'b1)
  ) u_dut (
    .i_clk (clk), .i_reset (rst), .i_ce (ce), .i_sync (sync),
    .i_sample (sample), .o_result (r1), .o_valid (v1),
    .o_sync (s1), .o_resync (rs1)
  );

  fft_reorder_buf #(
    .LGSIZE (LG), .WIDTH (W), .OPT_BITREV (1'b0)
  ) u_dut_nr (
    .i_clk (clk), .i_reset (rst), .i_ce (ce), .i_sync (sync),
    .i_sample (sample), .o_result (r2), .o_valid (v2),
    .o_sync (s2), .o_resync (rs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev(input int k);
    int r, a;
    r = 0;
    a = k;
    for (int i = 0; i < LG; i++) begin
      r = r * 2 + a % 2;
      a = a / 2;
    end
    return rev_ret(r);
  endfunction

  function automatic int rev_ret(input int r);
    return r;
  endfunction

  // Reference model: frames collected sample by sample; each completed
  // frame schedules its N outputs at fixed ce indices after completion.
  int           g = 0;
  bit           m_active = 1'b0;
  int           m_pos = 0;
  logic [W-1:0] fbuf [N];
  bit           ev [ARR];
  bit           es [ARR];
  logic [W-1:0] ed1 [ARR];
  logic [W-1:0] ed2 [ARR];
  bit           m_valid = 1'b0;
  bit           m_sync = 1'b0;
  bit           m_resync = 1'b0;
  logic [W-1:0] m_r1 = '0;
  logic [W-1:0] m_r2 = '0;

  bit           cap_on = 1'b0;
  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];

  task automatic drop_pending();
    for (int i = g; i < g + 3 * N && i < ARR; i++) begin
      ev[i] = 1'b0;
      es[i] = 1'b0;
    end
  endtask

  task automatic model(input bit c, input bit s, input bit r,
                       input logic [W-1:0] d);
    m_resync = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_valid  = 1'b0;
      m_sync   = 1'b0;
      m_r1     = '0;
      m_r2     = '0;
      drop_pending();
    end else if (c) begin
      if (s) begin
        if (m_active && m_pos != 0) begin
          m_resync = 1'b1;
          drop_pending();
        end
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (m_active) begin
        fbuf[m_pos] = d;
        m_pos++;
        if (m_pos == N) begin
          for (int k = 0; k < N; k++) begin
            ev[g + 2 + k]  = 1'b1;
            es[g + 2 + k]  = (k == 0);
            ed1[g + 2 + k] = fbuf[rev(k)];
            ed2[g + 2 + k] = fbuf[k];
          end
          m_pos = 0;
        end
      end
      m_valid = ev[g];
      m_sync  = es[g];
      if (m_valid) begin
        m_r1 = ed1[g];
        m_r2 = ed2[g];
      end
      g++;
    end
  endtask

  task automatic tick(input bit c, input bit s, input bit r,
                      input logic [W-1:0] d);
    @(negedge clk);
    ce     = c;
    sync   = s;
    rst    = r;
    sample = d;
    @(posedge clk);
    model(c, s, r, d);
    #1;
    chk("valid", v1, m_valid);
    chk("sync", s1, m_sync);
    chk("result", r1, m_r1);
    chk("resync", rs1, m_resync);
    chk("nr_valid", v2, m_valid);
    chk("nr_sync", s2, m_sync);
    chk("nr_result", r2, m_r2);
    chk("nr_resync", rs2, m_resync);
    if (cap_on && c && v1) q1.push_back(r1);
    if (cap_on && c && v2) q2.push_back(r2);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, '0);
  endtask

  // Three synced frames 0..23, then free-running data without sync.
  task automatic three_frames(input bit toggle_ce, input int n_ce);
    int  ci;
    bit  c;
    ci = 0;
    while (ci < n_ce) begin
      c = toggle_ce ? ~c : 1'b1;
      if (!toggle_ce) c = 1'b1;
      if (c) begin
        tick(1'b1, (ci < 24) && (ci % N == 0), 1'b0, W'(ci));
        ci++;
      end else begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, W'($urandom));
      end
    end
  endtask

  task automatic check_order(input string tag);
    logic [W-1:0] gv;
    int           ri;
    chk({tag, "_cnt"}, (q1.size() >= 24), 1);
    for (int i = 0; i < 24; i++) begin
      gv = 'x;
      if (i < q1.size()) gv = q1[i];
      ri = (i / N) * N + rev(i % N);
      chk({tag, "_rev"}, gv, ri);
      gv = 'x;
      if (i < q2.size()) gv = q2[i];
      chk({tag, "_nat"}, gv, i);
    end
  endtask

  initial begin
    int  n;
    bit  c, s, r;
    logic [7:0] rev_tbl [N];

    rev_tbl = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Reset state and first frame / continuous frames.
    do_reset();
    q1.delete();
    q2.delete();
    cap_on = 1'b1;
    three_frames(1'b0, 40);
    cap_on = 1'b0;
    check_order("cont");
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] gv;
      gv = 'x;
      if (k < q1.size()) gv = q1[k];
      chk("frame0_tbl", gv, rev_tbl[k]);
    end

    // Mid-frame sync drops the partial frame.
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 8'hA0);
    for (int i = 1; i < 5; i++) tick(1'b1, 1'b0, 1'b0, W'(8'hA0 + i));
    tick(1'b1, 1'b1, 1'b0, 8'h50);
    for (int i = 1; i < 2 * N + 4; i++) tick(1'b1, 1'b0, 1'b0, W'(8'h50 + i));

    // Clock enable toggling every other clock.
    do_reset();
    q1.delete();
    q2.delete();
    cap_on = 1'b1;
    three_frames(1'b1, 40);
    cap_on = 1'b0;
    check_order("ce_tog");

    // Reset while frame 2 is being output, then idle, then restart.
    do_reset();
    three_frames(1'b0, 28);
    tick(1'b1, 1'b0, 1'b1, 8'hEE);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, W'($urandom));
    tick(1'b1, 1'b1, 1'b0, 8'h30);
    for (int i = 1; i < 2 * N + 4; i++) tick(1'b1, 1'b0, 1'b0, W'(8'h30 + i));

    // Random traffic: sparse ce, frame-boundary and mid-frame syncs.
    n = 0;
    while (n < 2500 && g < ARR - 4 * N) begin
      c = ($urandom_range(0, 3) != 0);
      if (m_active && m_pos == 0)
        s = ($urandom_range(0, 1) == 0);
      else
        s = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 399) == 0);
      tick(c, s, r, W'($urandom));
      n++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
